// File: rtl/imem_boot_loader.sv
// imem_boot_loader
// Receives a byte stream over valid/ready, assembles little-endian 32-bit
// words and writes them into instruction memory. The first word of the stream
// is the program length in words. The core is held in reset until the whole
// program has been written. Oversize programs are reported as an error.
module imem_boot_loader #(
  parameter int                 DEPTH     = 1024,
  parameter int                 ADDR_W    = 64,
  parameter logic [ADDR_W-1:0]  BASE_ADDR = '0
) (
  input  logic              Clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              reload,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_reset,
  output logic              done,
  output logic              error
);

  // Loader states
  localparam logic [1:0] ST_LEN  = 2'd0;  // collecting the 4-byte length header
  localparam logic [1:0] ST_LOAD = 2'd1;  // collecting program words
  localparam logic [1:0] ST_DONE = 2'd2;  // program loaded, core released
  localparam logic [1:0] ST_ERR  = 2'd3;  // declared length too large

  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  logic [1:0]        state_reg, state_next;
  logic [1:0]        byte_cnt_reg, byte_cnt_next;
  logic [31:0]       word_idx_reg, word_idx_next;
  logic [31:0]       len_reg, len_next;
  logic              imem_we_reg, imem_we_next;
  logic [ADDR_W-1:0] imem_addr_reg, imem_addr_next;
  logic [31:0]       imem_wdata_reg, imem_wdata_next;
  logic              core_reset_reg, core_reset_next;
  logic              done_reg, done_next;
  logic              error_reg, error_next;

  // Lower three bytes of the word under assembly; the fourth byte is taken
  // straight from in_data so the word completes in the accepting cycle.
  logic [7:0]        lane_reg [3];
  logic [31:0]       word_full;
  logic              accept;
  logic              last_byte;
  logic              clear_ctx;

  assign in_ready  = (state_reg == ST_LEN) || (state_reg == ST_LOAD);
  assign accept    = in_valid && in_ready;
  assign last_byte = accept && (byte_cnt_reg == 2'd3);
  assign word_full = {in_data, lane_reg[2], lane_reg[1], lane_reg[0]};
  assign clear_ctx = reload && ((state_reg == ST_DONE) || (state_reg == ST_ERR));

  // Byte lanes: lane gi captures the byte accepted while byte_cnt == gi
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_lane
      // Capture one byte lane; cleared on reset and reload
      always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
          lane_reg[gi] <= 8'h00;
        end else if (clear_ctx) begin
          lane_reg[gi] <= 8'h00;
        end else if (accept && (byte_cnt_reg == 2'(gi))) begin
          lane_reg[gi] <= in_data;
        end
      end
    end
  endgenerate

  // Next-state decode: header parsing, word writes, completion and reload
  always_comb begin
    state_next      = state_reg;
    byte_cnt_next   = byte_cnt_reg;
    word_idx_next   = word_idx_reg;
    len_next        = len_reg;
    imem_we_next    = 1'b0;
    imem_addr_next  = imem_addr_reg;
    imem_wdata_next = imem_wdata_reg;

    if (accept) begin
      byte_cnt_next = byte_cnt_reg + 2'd1;  // wraps 3 -> 0 on each word
    end

    unique case (state_reg)
      ST_LEN: begin
        if (last_byte) begin
          len_next      = word_full;
          word_idx_next = 32'd0;
          if (word_full == 32'd0) begin
            state_next = ST_DONE;
          end else if (word_full > DEPTH_W) begin
            state_next = ST_ERR;
          end else begin
            state_next = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        if (last_byte) begin
          imem_we_next    = 1'b1;
          imem_wdata_next = word_full;
          imem_addr_next  = BASE_ADDR + (ADDR_W'(word_idx_reg) << 2);
          word_idx_next   = word_idx_reg + 32'd1;
          // Final write and DONE entry share the same registered update
          if (word_idx_reg == len_reg - 32'd1) begin
            state_next = ST_DONE;
          end
        end
      end
      default: begin  // ST_DONE, ST_ERR: only reload leaves these
        if (reload) begin
          state_next    = ST_LEN;
          byte_cnt_next = 2'd0;
          word_idx_next = 32'd0;
          len_next      = 32'd0;
        end
      end
    endcase

    // Status flags track the state being entered; core_reset lags DONE by a cycle
    done_next       = (state_next == ST_DONE);
    error_next      = (state_next == ST_ERR);
    core_reset_next = (state_reg != ST_DONE);
  end

  // State and output registers; async reset discards any partial word or pending write
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state_reg      <= ST_LEN;
      byte_cnt_reg   <= 2'd0;
      word_idx_reg   <= 32'd0;
      len_reg        <= 32'd0;
      imem_we_reg    <= 1'b0;
      imem_addr_reg  <= BASE_ADDR;
      imem_wdata_reg <= 32'd0;
      core_reset_reg <= 1'b1;
      done_reg       <= 1'b0;
      error_reg      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      byte_cnt_reg   <= byte_cnt_next;
      word_idx_reg   <= word_idx_next;
      len_reg        <= len_next;
      imem_we_reg    <= imem_we_next;
      imem_addr_reg  <= imem_addr_next;
      imem_wdata_reg <= imem_wdata_next;
      core_reset_reg <= core_reset_next;
      done_reg       <= done_next;
      error_reg      <= error_next;
    end
  end

  assign imem_we    = imem_we_reg;
  assign imem_addr  = imem_addr_reg;
  assign imem_wdata = imem_wdata_reg;
  assign core_reset = core_reset_reg;
  assign done       = done_reg;
  assign error      = error_reg;

endmodule
